rpn_evaluator: RTL and testbench
================================

Name: rpn_evaluator

Overview:
- Consumes the postfix token stream produced by the shunting-yard converter (stb/ack handshake, 32-bit data, operator flag).
- Evaluates the expression on an internal operand stack.
- On the '=' token, presents the 32-bit result, or an error code, to the downstream consumer.
- Sits directly downstream of the converter in the RPN calculator datapath.

Parameters:
- DEPTH, 16, operand stack entries (power of two, >=2)
- PTR_W, $clog2(DEPTH)+1, stack-pointer / depth-count width

Ports:
- CLK  input  1  clock
- RST  input  1  reset (asynchronous, active-high)
- in_stb  input  1  token valid; held with data until in_ack
- in_data  input  32  operand value, or operator code in [2:0]
- in_is_operator  input  1  1 = in_data[2:0] is an operator code
- in_ack  output  1  one-cycle pulse: token consumed
- result_stb  output  1  result valid; held until result_ack
- result_data  output  32  result value, or error code when result_err=1
- result_err  output  1  result_data carries an error code
- result_ack  input  1  downstream has taken the result
- depth  output  PTR_W  current operand-stack occupancy (debug)

Behaviour:
- Reset is asynchronous and aborts any operation, including mid-token or mid-result.
  - in_ack, result_stb, result_err are 0; result_data is 0.
  - sp (= depth) is 0; state is IDLE; stack contents are don't-care.
- Operator codes (in_data[2:0]): 001 '*', 010 '+', 011 '-', 100 '='. Any other code with in_is_operator=1 is illegal (error 4).
- Handshake:
  - A token is sampled only in IDLE with in_stb=1.
  - in_ack is a registered one-cycle pulse. The upstream drops in_stb in the cycle after in_ack.
  - IDLE ignores in_stb while in_ack=1.
- Stack:
  - Register array mem[0..DEPTH-1], pointer sp.
  - TOP = mem[sp-1], NXT = mem[sp-2], read combinationally.
- States:
  - IDLE:
    - Number: if sp==DEPTH, error 2 -> EMIT. Otherwise mem[sp]<=in_data, sp<=sp+1, in_ack<=1, stay IDLE. Latency: ack 1 cycle after sample.
    - '*', '+', '-': latch op. If sp<2, error 1 -> EMIT. Otherwise -> EXEC.
    - '=': if sp!=1, error (1 if sp==0, else 3) -> EMIT. Otherwise result_data<=TOP, result_err<=0 -> EMIT.
    - Illegal code: error 4 -> EMIT.
  - EXEC:
    - r = NXT op TOP. Order matters for '-': "a b -" = a-b.
    - mem[sp-2]<=r, sp<=sp-1, in_ack<=1 -> IDLE. Operator ack arrives 2 cycles after sample.
  - EMIT:
    - result_stb<=1; sp<=0 (stack cleared after every '=' and every error) -> WAIT.
    - On error: result_err<=1, result_data<=code.
  - WAIT:
    - Hold result_stb, result_data, result_err until result_ack=1.
    - Then result_stb<=0, result_err<=0, in_ack<=1 (consumes the '=' or offending token) -> IDLE.
- Arithmetic: 32-bit two's complement, wrap-around. '*' keeps the low 32 bits of the product. No overflow flag.
- Error codes: 1 underflow, 2 stack overflow, 3 leftover operands at '=', 4 illegal operator.
- After any error, evaluation restarts from an empty stack with the next token.
- depth reflects sp, updated on the same edge as the stack write.
- result_ack while result_stb=0 is ignored.
- in_stb is not sampled in EXEC, EMIT or WAIT; the token stays pending upstream.

Test Plan:
- Tokens 3, 4, 2, '*', '+', '=' -> result_stb with result_data=11, result_err=0. depth goes 1,2,3,2,1 then 0 after EMIT. One in_ack per token (6 total).
- Tokens 10, 3, '-', '=' -> result 7 (not -3). Tokens 0x7FFFFFFF, 1, '+', '=' -> 0x80000000. Tokens 0x10000, 0x10000, '*', '=' -> 0.
- Tokens 5, '+' -> error 1 (result_err=1, result_data=1), depth=0 after ack. Following tokens 2, '=' -> result 2, err 0.
- DEPTH=16: 17 numbers -> 17th token produces error 2, depth 0. Tokens 1, 2, '=' -> error 3.
- Operator code 111 -> error 4. Hold result_ack low 10 cycles -> result_stb and data stable throughout, no in_ack until result_ack.
- Assert RST while in WAIT with result_stb=1 -> all outputs 0 and depth=0 asynchronously. Tokens 8, '=' after release -> result 8.

Source files
------------

// File: rtl/rpn_evaluator.sv
// Postfix expression evaluator: pushes operands onto a register stack, folds
// '*', '+', '-' onto the top two entries and reports the value (or an error) on '='.
module rpn_evaluator #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_stb,
    input  logic [31:0]      in_data,
    input  logic             in_is_operator,
    output logic             in_ack,
    output logic             result_stb,
    output logic [31:0]      result_data,
    output logic             result_err,
    input  logic             result_ack,
    output logic [PTR_W-1:0] depth
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = PTR_W - 1;

    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;

    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
    localparam logic [2:0] ERR_LEFTOVER  = 3'd3;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, EMIT, WAIT} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         sp, sp_d;
    logic [IDX_W-1:0]         top_idx, nxt_idx;
    logic signed [DATA_W-1:0] top, nxt;

    logic [2:0]               op_p0, op_d;
    logic [2:0]               err_code, code_d;
    logic                     err_pend, pend_d;
    logic                     ack_d, stb_d, err_d;
    logic [DATA_W-1:0]        data_d;

    logic                     wr_en;
    logic [IDX_W-1:0]         wr_idx;
    logic signed [DATA_W-1:0] wr_val;

    logic       take, is_num, is_arith, is_eq, full, few_ops;
    logic [2:0] code_in;

    // Wrap-around 32-bit arithmetic; '*' keeps only the low half of the product.
    function automatic logic signed [DATA_W-1:0] alu(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            OP_MUL:  alu = a * b;
            OP_SUB:  alu = a - b;
            default: alu = a + b;
        endcase
    endfunction

    // Index arithmetic wraps modulo DEPTH, so a full stack still addresses mem[DEPTH-1].
    assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
    assign nxt_idx = sp[IDX_W-1:0] - IDX_W'(2);
    assign top     = mem[top_idx];
    assign nxt     = mem[nxt_idx];

    assign code_in  = in_data[2:0];
    assign take     = (state == IDLE) && in_stb && !in_ack;
    assign is_num   = !in_is_operator;
    assign is_arith = in_is_operator &&
                      ((code_in == OP_MUL) || (code_in == OP_ADD) || (code_in == OP_SUB));
    assign is_eq    = in_is_operator && (code_in == OP_EQ);
    assign full     = (sp == PTR_W'(DEPTH));
    assign few_ops  = (sp < PTR_W'(2));
    assign depth    = sp;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    if (is_num)        state_nxt = full ? EMIT : IDLE;
                    else if (is_arith) state_nxt = few_ops ? EMIT : EXEC;
                    else               state_nxt = EMIT;
                end
            end
            EXEC:    state_nxt = IDLE;
            EMIT:    state_nxt = WAIT;
            WAIT:    state_nxt = result_ack ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack_d  = 1'b0;
        stb_d  = result_stb;
        err_d  = result_err;
        data_d = result_data;
        sp_d   = sp;
        code_d = err_code;
        pend_d = err_pend;
        op_d   = op_p0;
        wr_en  = 1'b0;
        wr_idx = sp[IDX_W-1:0];
        wr_val = in_data;
        case (state)
            IDLE: begin
                if (take) begin
                    pend_d = 1'b0;
                    if (is_num) begin
                        if (full) begin
                            code_d = ERR_OVERFLOW;
                            pend_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            sp_d  = sp + PTR_W'(1);
                            ack_d = 1'b1;
                        end
                    end else if (is_arith) begin
                        op_d = code_in;
                        if (few_ops) begin
                            code_d = ERR_UNDERFLOW;
                            pend_d = 1'b1;
                        end
                    end else if (is_eq) begin
                        if (sp == PTR_W'(1)) begin
                            data_d = top;
                            err_d  = 1'b0;
                        end else begin
                            code_d = (sp == '0) ? ERR_UNDERFLOW : ERR_LEFTOVER;
                            pend_d = 1'b1;
                        end
                    end else begin
                        code_d = ERR_ILLEGAL;
                        pend_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // "a b -" leaves a-b: NXT is the left operand.
                wr_en  = 1'b1;
                wr_idx = nxt_idx;
                wr_val = alu(op_p0, nxt, top);
                sp_d   = sp - PTR_W'(1);
                ack_d  = 1'b1;
            end
            EMIT: begin
                stb_d = 1'b1;
                sp_d  = '0;
                if (err_pend) begin
                    err_d  = 1'b1;
                    data_d = {{(DATA_W-3){1'b0}}, err_code};
                end
            end
            WAIT: begin
                // The ack here consumes the '=' or offending token held upstream.
                if (result_ack) begin
                    stb_d = 1'b0;
                    err_d = 1'b0;
                    ack_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_ack      <= 1'b0;
            result_stb  <= 1'b0;
            result_err  <= 1'b0;
            result_data <= '0;
            sp          <= '0;
            err_code    <= '0;
            err_pend    <= 1'b0;
        end else begin
            in_ack      <= ack_d;
            result_stb  <= stb_d;
            result_err  <= err_d;
            result_data <= data_d;
            sp          <= sp_d;
            err_code    <= code_d;
            err_pend    <= pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        op_p0 <= op_d;
        if (wr_en) mem[wr_idx] <= wr_val;
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Self-checking bench for rpn_evaluator: token sequences from a table, a result
// scoreboard fed as tokens are driven, plus hand sequences for latency, hold and reset.
module tb_rpn_evaluator;

    localparam int DEPTH = 16;
    localparam int PTR_W = 5;

    localparam logic [2:0] MUL = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd3;
    localparam logic [2:0] EQ  = 3'd4;

    logic             CLK;
    logic             RST;
    logic             in_stb;
    logic [31:0]      in_data;
    logic             in_is_operator;
    logic             in_ack;
    logic             result_stb;
    logic [31:0]      result_data;
    logic             result_err;
    logic             result_ack;
    logic [PTR_W-1:0] depth;

    rpn_evaluator #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_stb         (in_stb),
        .in_data        (in_data),
        .in_is_operator (in_is_operator),
        .in_ack         (in_ack),
        .result_stb     (result_stb),
        .result_data    (result_data),
        .result_err     (result_err),
        .result_ack     (result_ack),
        .depth          (depth)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          first;
        int          n;
        logic [32:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] toks[$];
    logic [32:0] exp_q[$];
    int          vstart    = 0;
    int          n_cmp     = 0;
    int          n_fail    = 0;
    int          ack_delay = 0;
    bit          mon_en    = 1'b1;
    int          ack_cnt   = 0;
    int          mdep      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] N(input logic [31:0] x);
        return {1'b0, x};
    endfunction

    function automatic logic [32:0] O(input logic [2:0] c);
        return {1'b1, 29'd0, c};
    endfunction

    function automatic void T(input logic [32:0] t);
        toks.push_back(t);
    endfunction

    function automatic void V(input string name, input logic e, input logic [31:0] d);
        vec_t r;
        r.first = vstart;
        r.n     = toks.size() - vstart;
        r.exp   = {e, d};
        r.name  = name;
        vecs.push_back(r);
        vstart = toks.size();
    endfunction

    // Expected occupancy after a token has been acknowledged.
    function automatic void mdep_upd(input logic [32:0] t);
        if (!t[32]) mdep = (mdep == DEPTH) ? 0 : mdep + 1;
        else if (t[2:0] == MUL || t[2:0] == ADD || t[2:0] == SUB) mdep = (mdep >= 2) ? mdep - 1 : 0;
        else mdep = 0;
    endfunction

    task automatic send(input logic op, input logic [31:0] d, output int lat);
        bit got;
        got = 1'b0;
        @(negedge CLK);
        while (in_ack) @(negedge CLK);
        in_data        = d;
        in_is_operator = op;
        in_stb         = 1'b1;
        lat            = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge CLK);
            #1;
            lat++;
            if (in_ack) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got no in_ack, want in_ack within 200 cycles (token 0x%0h)", d);
        end
        in_stb = 1'b0;
    endtask

    always @(negedge CLK) if (in_ack) ack_cnt <= ack_cnt + 1;

    // Result consumer: compares against the scoreboard, optionally holds off result_ack.
    initial begin : monitor
        logic [32:0] got;
        logic [32:0] exp;
        bit          stable;
        result_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en && result_stb && !RST) begin
                got = {result_err, result_data};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h, want no result", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("result", got, exp);
                end
                stable = 1'b1;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge CLK);
                    if (!result_stb || {result_err, result_data} != got || in_ack) stable = 1'b0;
                end
                if (ack_delay > 0) check("hold_stable", stable, 1);
                result_ack = 1'b1;
                @(negedge CLK);
                result_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, want finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          lat;
        int          a0;
        bit          seen;
        logic [32:0] t;

        RST            = 1'b1;
        in_stb         = 1'b0;
        in_data        = '0;
        in_is_operator = 1'b0;

        T(N(3)); T(N(4)); T(N(2)); T(O(MUL)); T(O(ADD)); T(O(EQ)); V("mixed", 1'b0, 32'd11);
        T(N(10)); T(N(3)); T(O(SUB)); T(O(EQ));                  V("sub_order", 1'b0, 32'd7);
        T(N(32'h7FFF_FFFF)); T(N(1)); T(O(ADD)); T(O(EQ));       V("add_wrap", 1'b0, 32'h8000_0000);
        T(N(32'h1_0000)); T(N(32'h1_0000)); T(O(MUL)); T(O(EQ)); V("mul_wrap", 1'b0, 32'd0);
        T(N(5)); T(O(ADD));                                      V("underflow", 1'b1, 32'd1);
        T(N(2)); T(O(EQ));                                       V("after_err", 1'b0, 32'd2);
        for (int i = 1; i <= DEPTH + 1; i++) T(N(i));            V("overflow", 1'b1, 32'd2);
        T(N(1)); T(N(2)); T(O(EQ));                              V("leftover", 1'b1, 32'd3);
        T(O(EQ));                                                V("eq_empty", 1'b1, 32'd1);
        T(N(32'hFFFF_FFFB)); T(N(3)); T(O(MUL)); T(O(EQ));       V("signed_mul", 1'b0, 32'hFFFF_FFF1);
        T(N(2)); T(N(3)); T(O(SUB)); T(O(EQ));                   V("neg_sub", 1'b0, 32'hFFFF_FFFF);
        T(O(3'd0));                                              V("illegal0", 1'b1, 32'd4);

        repeat (3) @(negedge CLK);
        check("rst in_ack", in_ack, 0);
        check("rst result_stb", result_stb, 0);
        check("rst result_err", result_err, 0);
        check("rst result_data", result_data, 0);
        check("rst depth", depth, 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < vecs.size(); v++) begin
            a0 = ack_cnt;
            for (int j = 0; j < vecs[v].n; j++) begin
                t = toks[vecs[v].first + j];
                if (j == vecs[v].n - 1) exp_q.push_back(vecs[v].exp);
                send(t[32], t[31:0], lat);
                mdep_upd(t);
                check({vecs[v].name, " depth"}, depth, mdep);
            end
            @(negedge CLK);
            #1;
            check({vecs[v].name, " ack_count"}, ack_cnt - a0, vecs[v].n);
        end

        // Acknowledge latency: one cycle for a push, two for an arithmetic operator.
        send(1'b0, 32'd4, lat);
        check("lat number", lat, 1);
        send(1'b0, 32'd5, lat);
        check("lat number2", lat, 1);
        send(1'b1, {29'd0, ADD}, lat);
        check("lat operator", lat, 2);
        check("lat depth", depth, 1);
        exp_q.push_back({1'b0, 32'd9});
        send(1'b1, {29'd0, EQ}, lat);
        mdep = 0;

        // Illegal code 111 with result_ack held off for 10 cycles.
        ack_delay = 10;
        exp_q.push_back({1'b1, 32'd4});
        send(1'b1, 32'd7, lat);
        ack_delay = 0;
        check("illegal depth", depth, 0);
        check("illegal ack_late", (lat >= 12) ? 1 : 0, 1);

        // Asynchronous reset while a result is being presented.
        mon_en = 1'b0;
        send(1'b0, 32'd8, lat);
        @(negedge CLK);
        in_data        = {29'd0, EQ};
        in_is_operator = 1'b1;
        in_stb         = 1'b1;
        seen           = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLK);
            if (result_stb) seen = 1'b1;
        end
        check("pre_rst result_stb", result_stb, 1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst in_ack", in_ack, 0);
        check("async_rst result_stb", result_stb, 0);
        check("async_rst result_err", result_err, 0);
        check("async_rst result_data", result_data, 0);
        check("async_rst depth", depth, 0);
        in_stb = 1'b0;
        @(negedge CLK);
        RST    = 1'b0;
        mon_en = 1'b1;
        mdep   = 0;
        send(1'b0, 32'd8, lat);
        check("post_rst depth", depth, 1);
        exp_q.push_back({1'b0, 32'd8});
        send(1'b1, {29'd0, EQ}, lat);
        check("post_rst depth_end", depth, 0);

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
